// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch buffer entry type and fetch constants
package fetch_pkg;

  localparam int FETCH_AW    = 32;
  localparam int FETCH_DW    = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [FETCH_DW-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
    logic                err;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous fetch buffer of fetch_entry_t with flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

  // Flush wins over any same-cycle push or pop; pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) begin
        mem_q[wr_ptr_q] <= entry_i;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC, ROM request issue and decoder-facing fetch buffer; IFETCH_ALIGN_CHECK_EN traps misaligned redirects
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  rom_req,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  fetch_err
);

  localparam int CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
  localparam int OW = CW + 1;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  halted;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [CW-1:0]         count;
  logic [OW-1:0]         occupancy;
  fetch_entry_t          push_entry;
  fetch_entry_t          head;

  assign pop       = instr_valid & instr_ready;
  assign occupancy = {1'b0, count} + OW'(inflight_q) - OW'(pop);
  // Gating with rst_n keeps the strobe low while reset is held.
  assign issue     = rst_n & ~redirect & ~halted & (occupancy < OW'(FIFO_DEPTH));
  assign push      = inflight_q & ~redirect;

  assign rom_req  = issue;
  assign rom_addr = pc_q;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic halted_q, halted_d;
  logic inflight_err_q, inflight_err_d;
  logic misaligned;

  assign misaligned = redirect & (redirect_pc[1:0] != 2'b00);
  assign halted     = halted_q;

  // A misaligned target reuses the response slot to deliver a NOP with err.
  assign push_entry.pc    = inflight_pc_q;
  assign push_entry.instr = inflight_err_q ? NOP_INSTR : rom_rdata;
  assign push_entry.err   = inflight_err_q;
  assign fetch_err        = instr_valid & head.err;
`else
  logic unused_redirect_lsb;
  logic unused_head_err;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign unused_head_err     = head.err;
  assign halted              = 1'b0;

  assign push_entry.pc    = inflight_pc_q;
  assign push_entry.instr = rom_rdata;
  assign push_entry.err   = 1'b0;
  assign fetch_err        = 1'b0;
`endif

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (issue) begin
      pc_d          = pc_q + ADDR_WIDTH'(INSTR_BYTES);
      inflight_pc_d = pc_q;
    end
    if (redirect) begin
      pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    end
`ifdef IFETCH_ALIGN_CHECK_EN
    inflight_err_d = 1'b0;
    halted_d       = halted_q;
    if (redirect) begin
      halted_d = misaligned;
      if (misaligned) begin
        inflight_d     = 1'b1;
        inflight_pc_d  = redirect_pc;
        inflight_err_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
      halted_q       <= 1'b0;
      inflight_err_q <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
`ifdef IFETCH_ALIGN_CHECK_EN
      halted_q       <= halted_d;
      inflight_err_q <= inflight_err_d;
`endif
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect),
    .head_o  (head),
    .count_o (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch (two instances: RESET_PC 0 and 0xFFFF_FFF8)
`timescale 1ns/1ps
module tb_instr_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_req, rom_req1;
  logic [31:0] rom_addr, rom_addr1;
  logic [31:0] rom_rdata = '0, rom_rdata1 = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_valid1;
  logic        instr_ready = 1'b1;
  logic [31:0] instr, instr1;
  logic [31:0] instr_pc, instr_pc1;
  logic        fetch_err, fetch_err1;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t exp1[$];

  always #5 clk = ~clk;

  instr_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .rom_req(rom_req), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .fetch_err(fetch_err)
  );

  instr_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .rom_req(rom_req1), .rom_addr(rom_addr1), .rom_rdata(rom_rdata1),
    .redirect(1'b0), .redirect_pc(32'h0), .instr_valid(instr_valid1),
    .instr_ready(1'b1), .instr(instr1), .instr_pc(instr_pc1), .fetch_err(fetch_err1)
  );

  function automatic logic [31:0] rom_word(logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  // ROM answers exactly one cycle after a request; junk otherwise.
  always @(posedge clk) begin
    rom_rdata  <= rom_req  ? rom_word(rom_addr)  : 32'hDEAD_BEEF;
    rom_rdata1 <= rom_req1 ? rom_word(rom_addr1) : 32'hDEAD_BEEF;
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.instr = rom_word(pc);
    e.err = 1'b0;
    return e;
  endfunction

  task automatic load_seq(logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 48; i++) exp_q.push_back(mk(start + 32'(4 * i)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_instr observed pc=%0h expected none", instr_pc);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_instr_pc", 64'(instr_pc), 64'(e.pc));
        check("sb_instr", 64'(instr), 64'(e.instr));
        check("sb_fetch_err", 64'(fetch_err), 64'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && instr_valid1 && exp1.size() != 0) begin
      exp_t e;
      e = exp1.pop_front();
      check("wrap_instr_pc", 64'(instr_pc1), 64'(e.pc));
      check("wrap_instr", 64'(instr1), 64'(e.instr));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    mid();
    check("rst_rom_req", 64'(rom_req), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'h0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'h0);
    check("rst_instr_pc", 64'(instr_pc), 64'h0);
    check("rst_fetch_err", 64'(fetch_err), 64'd0);
    check("rst_rom_addr1", 64'(rom_addr1), 64'hFFFF_FFF8);

    load_seq(32'h0);
    exp1.push_back(mk(32'hFFFF_FFF8));
    exp1.push_back(mk(32'hFFFF_FFFC));
    exp1.push_back(mk(32'h0000_0000));
    exp1.push_back(mk(32'h0000_0004));

    // Cycle 0 after release: first request at RESET_PC.
    step(); rst_n = 1'b1;
    mid();
    check("c0_rom_req", 64'(rom_req), 64'd1);
    check("c0_rom_addr", 64'(rom_addr), 64'h0);
    check("c0_instr_valid", 64'(instr_valid), 64'd0);
    check("c0_rom_addr1", 64'(rom_addr1), 64'hFFFF_FFF8);
    step(); mid();
    check("c1_rom_addr", 64'(rom_addr), 64'h4);
    check("c1_instr_valid", 64'(instr_valid), 64'd0);
    step(); mid();
    check("c2_instr_valid", 64'(instr_valid), 64'd1);
    check("c2_instr_pc", 64'(instr_pc), 64'h0);
    for (int i = 3; i < 10; i++) begin
      step(); mid();
      check("tput_valid", 64'(instr_valid), 64'd1);
      check("tput_rom_req", 64'(rom_req), 64'd1);
    end

    // Backpressure for 5 cycles.
    step(); instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid();
      check("stall_rom_req", 64'(rom_req), 64'd0);
      check("stall_valid", 64'(instr_valid), 64'd1);
      check("stall_instr_pc", 64'(instr_pc), 64'(exp_q[0].pc));
      check("stall_instr", 64'(instr), 64'(exp_q[0].instr));
      step();
    end
    instr_ready = 1'b1;
    mid();
    check("resume_rom_req", 64'(rom_req), 64'd1);
    repeat (4) step();

    // Redirect to 0x40 with one buffered entry and one read in flight.
    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    mid();
    check("rd40_rom_req", 64'(rom_req), 64'd0);
    #1 load_seq(32'h40);
    step(); redirect = 1'b0; instr_ready = 1'b1;
    mid();
    check("rd40_n1_rom_req", 64'(rom_req), 64'd1);
    check("rd40_n1_rom_addr", 64'(rom_addr), 64'h40);
    check("rd40_n1_valid", 64'(instr_valid), 64'd0);
    step(); mid();
    check("rd40_n2_valid", 64'(instr_valid), 64'd0);
    step(); mid();
    check("rd40_n3_valid", 64'(instr_valid), 64'd1);
    check("rd40_n3_instr_pc", 64'(instr_pc), 64'h40);
    repeat (3) step();

    // Redirect to 0, then redirect again while pc 0x8 is being accepted.
    redirect = 1'b1; redirect_pc = 32'h0;
    mid();
    #1 load_seq(32'h0);
    step(); redirect = 1'b0;
    repeat (4) step();
    redirect = 1'b1; redirect_pc = 32'h100;
    mid();
    check("hs_instr_valid", 64'(instr_valid), 64'd1);
    check("hs_instr_pc", 64'(instr_pc), 64'h8);
    #1 load_seq(32'h100);
    step(); redirect = 1'b0;
    mid();
    check("rd100_rom_addr", 64'(rom_addr), 64'h100);
    step(); step(); mid();
    check("rd100_n3_valid", 64'(instr_valid), 64'd1);
    check("rd100_n3_instr_pc", 64'(instr_pc), 64'h100);
    repeat (3) step();

    // Misaligned redirect target.
    redirect = 1'b1; redirect_pc = 32'h42;
    mid();
`ifdef IFETCH_ALIGN_CHECK_EN
    #1;
    exp_q.delete();
    begin
      exp_t e;
      e.pc = 32'h42; e.instr = 32'h0000_0013; e.err = 1'b1;
      exp_q.push_back(e);
    end
    step(); redirect = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
        mid();
        check("mis_rom_req", 64'(rom_req), 64'd0);
        if (instr_valid) begin
          seen = 1'b1;
          check("mis_fetch_err", 64'(fetch_err), 64'd1);
          check("mis_instr_pc", 64'(instr_pc), 64'h42);
        end
        step();
      end
      check("mis_entry_seen", 64'(seen), 64'd1);
    end
    for (int i = 0; i < 3; i++) begin
      mid();
      check("halt_rom_req", 64'(rom_req), 64'd0);
      check("halt_valid", 64'(instr_valid), 64'd0);
      step();
    end
    redirect = 1'b1; redirect_pc = 32'h80;
    mid();
    #1 load_seq(32'h80);
    step(); redirect = 1'b0;
    mid();
    check("rd80_rom_req", 64'(rom_req), 64'd1);
    check("rd80_rom_addr", 64'(rom_addr), 64'h80);
    step(); step(); mid();
    check("rd80_instr_pc", 64'(instr_pc), 64'h80);
`else
    #1 load_seq(32'h40);
    step(); redirect = 1'b0;
    mid();
    check("mis_rom_addr", 64'(rom_addr), 64'h40);
    step(); step(); mid();
    check("mis_instr_pc", 64'(instr_pc), 64'h40);
    check("mis_fetch_err", 64'(fetch_err), 64'd0);
`endif
    repeat (3) step();

    // Reset in the middle of streaming.
    rst_n = 1'b0;
    mid();
    check("mrst_valid", 64'(instr_valid), 64'd0);
    check("mrst_rom_req", 64'(rom_req), 64'd0);
    check("mrst_rom_addr", 64'(rom_addr), 64'h0);
    #1 load_seq(32'h0);
    step(); rst_n = 1'b1;
    mid();
    check("mrst_c0_rom_req", 64'(rom_req), 64'd1);
    step(); step(); mid();
    check("mrst_c2_valid", 64'(instr_valid), 64'd1);
    check("mrst_c2_instr_pc", 64'(instr_pc), 64'h0);
    repeat (4) step();

    check("wrap_consumed", 64'(exp1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
